// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction ROM,
// buffers the fetched word until decode accepts it, and applies branch/exception redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        ID_allow_in,
    input  logic        jbr_taken,
    input  logic [31:0] jbr_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    output logic        IF_over,
    output logic [63:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_DATA = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        br_pending_q;
    logic [31:0] br_target_q;
    logic [31:0] inst_buf_q;
    logic        inst_valid;
    logic        handoff;

    assign inst_valid = (state_q == S_DATA) || (state_q == S_HOLD);
    assign IF_over    = inst_valid && !exc_valid;
    assign handoff    = IF_over && ID_allow_in;

    // A live branch in ID overrides one captured earlier; both apply after the delay slot.
    assign pc_d = jbr_taken    ? jbr_target  :
                  br_pending_q ? br_target_q :
                                 pc_q + 32'd4;

    always_comb begin
        IF_inst = 32'd0;
        unique case (state_q)
            S_DATA:  IF_inst = inst_rdata;
            S_HOLD:  IF_inst = inst_buf_q;
            default: IF_inst = 32'd0;
        endcase
    end

    assign inst_addr = pc_q;
    assign IF_pc     = pc_q;
    assign IF_ID_bus = {pc_q, IF_inst};

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            br_pending_q <= 1'b0;
            br_target_q  <= 32'd0;
            inst_buf_q   <= 32'd0;
        end else if (exc_valid) begin
            state_q      <= S_REQ;
            pc_q         <= exc_pc;
            br_pending_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    if (ID_allow_in) begin
                        pc_q    <= pc_d;
                        state_q <= S_REQ;
                    end else begin
                        inst_buf_q <= inst_rdata;
                        state_q    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ID_allow_in) begin
                        pc_q    <= pc_d;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase

            // Remember a redirect whose branch may leave ID before the delay slot is handed off.
            if (handoff) begin
                br_pending_q <= 1'b0;
            end else if (jbr_taken) begin
                br_pending_q <= 1'b1;
                br_target_q  <= jbr_target;
            end
        end
    end

endmodule
